// File: rtl/if_id_fifo.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO with valid/ready on both sides.
// Flush and reset empty the queue in one cycle; head outputs read NOP when empty.
module if_id_fifo #(
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INT_W    = 8,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h00000013)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [INST_W-1:0]            inst_i,
    input  logic [ADDR_W-1:0]            inst_addr_i,
    input  logic                         prdt_taken_i,
    input  logic [INT_W-1:0]             int_flag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [INST_W-1:0]            inst_o,
    output logic [ADDR_W-1:0]            inst_addr_o,
    output logic                         prdt_taken_o,
    output logic [INT_W-1:0]             int_flag_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned ENT_W = INST_W + ADDR_W + 1 + INT_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic [ENT_W-1:0] head;

    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign in_ready_o  = (count_q != FULL);
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign count_o     = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: empty-masking hides stale contents.
    always_ff @(posedge clk) begin
        if (rst && !flush_i && push) begin
            mem_q[wptr_q] <= {inst_i, inst_addr_i, prdt_taken_i, int_flag_i};
        end
    end

    assign head = mem_q[rptr_q];

    always_comb begin
        inst_o       = NOP_INST;
        inst_addr_o  = '0;
        prdt_taken_o = 1'b0;
        int_flag_o   = '0;
        if (out_valid_o) begin
            {inst_o, inst_addr_o, prdt_taken_o, int_flag_o} = head;
        end
    end

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed and randomised checks of if_id_fifo at DEPTH=4 against hand-computed values
// and a queue model.
module tb_if_id_fifo;

    logic        clk = 1'b0;
    logic        rst, flush_i, in_valid_i, out_ready_i, prdt_taken_i;
    logic        in_ready_o, out_valid_o, prdt_taken_o;
    logic [31:0] inst_i, inst_addr_i, inst_o, inst_addr_o;
    logic [7:0]  int_flag_i, int_flag_o;
    logic [2:0]  count_o;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    if_id_fifo #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .prdt_taken_i(prdt_taken_i), .int_flag_i(int_flag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .prdt_taken_o(prdt_taken_o), .int_flag_o(int_flag_o),
        .count_o(count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A50000;
    endfunction

    // Drive a fetch beat whose payload is derived from the address.
    task automatic drive(input logic v, input logic [31:0] a, input logic r);
        in_valid_i   = v;
        inst_addr_i  = a;
        inst_i       = inst_of(a);
        prdt_taken_i = a[2];
        int_flag_i   = a[9:2];
        out_ready_i  = r;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, out_valid_o, 0);
        chk({tag, ".ready"}, in_ready_o, 1);
        chk({tag, ".count"}, count_o, 0);
        chk({tag, ".inst"}, inst_o, 32'h00000013);
        chk({tag, ".addr"}, inst_addr_o, 0);
        chk({tag, ".prdt"}, prdt_taken_o, 0);
        chk({tag, ".int"}, int_flag_o, 0);
    endtask

    logic [31:0] sb[$];
    int          mc;
    logic        v, r, p_push, p_pop;
    logic [31:0] a, na;

    initial begin
        rst = 1'b0; flush_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        step; step;
        chk_empty("reset");
        rst = 1'b1;

        // Single push with explicit payload.
        in_valid_i = 1'b1; inst_i = 32'h00500093; inst_addr_i = 32'h100;
        prdt_taken_i = 1'b1; int_flag_i = 8'h01; out_ready_i = 1'b0;
        step;
        chk("single.valid", out_valid_o, 1);
        chk("single.inst", inst_o, 32'h00500093);
        chk("single.addr", inst_addr_o, 32'h100);
        chk("single.prdt", prdt_taken_o, 1);
        chk("single.int", int_flag_o, 8'h01);
        chk("single.count", count_o, 1);
        drive(1'b0, 32'h0, 1'b1);
        step;
        chk_empty("single_pop");

        // Fill to DEPTH, then an extra push is refused.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0);
            step;
        end
        chk("fill.count", count_o, 4);
        chk("fill.ready", in_ready_o, 0);
        drive(1'b1, 32'h110, 1'b0);
        step;
        chk("fill.over_count", count_o, 4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            chk("drain.addr", inst_addr_o, 32'h100 + 32'(4 * i));
            chk("drain.inst", inst_o, inst_of(32'h100 + 32'(4 * i)));
            step;
            if (i == 0) chk("drain.bubble_ready", in_ready_o, 1);
        end
        chk_empty("drain_end");

        // Streaming at occupancy 2 across several pointer wraps.
        drive(1'b1, 32'h200, 1'b0); step;
        drive(1'b1, 32'h204, 1'b0); step;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h208 + 32'(4 * i), 1'b1);
            chk("stream.addr", inst_addr_o, 32'h200 + 32'(4 * i));
            chk("stream.count", count_o, 2);
            step;
        end
        drive(1'b0, 32'h0, 1'b1); step; step;
        chk_empty("stream_end");

        // Flush at count 3 with a simultaneous push.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b0);
            step;
        end
        chk("flush.pre_count", count_o, 3);
        flush_i = 1'b1;
        drive(1'b1, 32'h30C, 1'b1);
        step;
        flush_i = 1'b0;
        chk_empty("flush");
        drive(1'b1, 32'h400, 1'b0);
        step;
        chk("post_flush.count", count_o, 1);
        chk("post_flush.addr", inst_addr_o, 32'h400);
        drive(1'b0, 32'h0, 1'b1);
        step;
        chk("post_flush.pop_count", count_o, 0);

        // Reset at count 2 during push/pop.
        drive(1'b1, 32'h500, 1'b0); step;
        drive(1'b1, 32'h504, 1'b0); step;
        rst = 1'b0;
        drive(1'b1, 32'h508, 1'b1);
        step;
        rst = 1'b1;
        chk_empty("mid_reset");
        drive(1'b1, 32'h600, 1'b0);
        step;
        chk("post_reset.count", count_o, 1);
        chk("post_reset.addr", inst_addr_o, 32'h600);
        drive(1'b0, 32'h0, 1'b1);
        step;

        // Random valid/ready against a queue model.
        mc = 0;
        na = 32'h1000;
        sb.delete();
        for (int c = 0; c < 3000; c++) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            drive(v, na, r);
            chk("rand.ready", in_ready_o, mc != 4);
            chk("rand.valid", out_valid_o, mc != 0);
            chk("rand.count", count_o, mc);
            if (mc != 0) begin
                a = sb[0];
                chk("rand.addr", inst_addr_o, a);
                chk("rand.inst", inst_o, inst_of(a));
            end else begin
                chk("rand.nop", inst_o, 32'h00000013);
            end
            p_push = v && (mc != 4);
            p_pop  = r && (mc != 0);
            if (p_pop) void'(sb.pop_front());
            if (p_push) begin
                sb.push_back(na);
                na = na + 32'h4;
            end
            mc = mc + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
            step;
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
